// File: rtl/harp_pkg.sv
// harp_pkg: constants and parser state encoding shared by both ends of the
// Harp clock-synchronization link.
//   HARP_SYNC0 / HARP_SYNC1 : the two header bytes that open every packet
//   HARP_PKT_BYTES          : total packet length (2 header + 4 timestamp bytes)
//   parser_state_e          : receive parser states, exported for debug/checkers
package harp_pkg;

  localparam logic [7:0] HARP_SYNC0     = 8'hAA;
  localparam logic [7:0] HARP_SYNC1     = 8'hAF;
  localparam int         HARP_PKT_BYTES = 6;

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    SYNC1 = 3'd1,
    B0    = 3'd2,
    B1    = 3'd3,
    B2    = 3'd4,
    B3    = 3'd5
  } parser_state_e;

endpackage

// File: rtl/harp_packet_parser.sv
// harp_packet_parser: byte-level parser for the Harp timestamp packet
// (AA AF s0 s1 s2 s3, seconds little-endian) with an inter-byte timeout.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   run_i          : low holds the parser in HUNT
//   uart_data_i    : received byte, qualified by uart_valid_i
//   uart_valid_i   : one-cycle strobe per received byte
//   ts_o           : assembled timestamp, meaningful only while ts_valid_o is high
//   ts_valid_o     : combinational strobe in the cycle the final byte is presented
//   pkt_error_o    : registered one-cycle pulse on a bad header byte or timeout
//   state_o        : current parser state (debug)
module harp_packet_parser
  import harp_pkg::*;
#(
  parameter int BYTE_TIMEOUT_CYCLES = 2000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              run_i,
  input  logic [7:0]                        uart_data_i,
  input  logic                              uart_valid_i,
  output logic [8*(HARP_PKT_BYTES-2)-1:0]   ts_o,
  output logic                              ts_valid_o,
  output logic                              pkt_error_o,
  output parser_state_e                     state_o
);

  localparam int TS_W = 8 * (HARP_PKT_BYTES - 2);
  localparam int TW   = $clog2(BYTE_TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(BYTE_TIMEOUT_CYCLES - 1);

  parser_state_e    state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [TS_W-9:0]  ts_q, ts_d;
  logic             err_q, err_d;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    ts_d       = ts_q;
    err_d      = 1'b0;
    ts_valid_o = 1'b0;

    if (state_q != HUNT && timer_q != '0) begin
      timer_d = timer_q - 1'b1;
    end

    if (!run_i) begin
      state_d = HUNT;
    end else if (uart_valid_i) begin
      // A byte arriving on the expiry cycle wins over the timeout.
      timer_d = TIMEOUT_LOAD;
      case (state_q)
        HUNT: begin
          if (uart_data_i == HARP_SYNC0) state_d = SYNC1;
        end
        SYNC1: begin
          if (uart_data_i == HARP_SYNC1) begin
            state_d = B0;
          end else if (uart_data_i == HARP_SYNC0) begin
            state_d = SYNC1;
          end else begin
            state_d = HUNT;
            err_d   = 1'b1;
          end
        end
        B0: begin
          ts_d[7:0] = uart_data_i;
          state_d   = B1;
        end
        B1: begin
          ts_d[15:8] = uart_data_i;
          state_d    = B2;
        end
        B2: begin
          ts_d[23:16] = uart_data_i;
          state_d     = B3;
        end
        B3: begin
          ts_valid_o = 1'b1;
          state_d    = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end else if (state_q != HUNT && timer_q == '0) begin
      state_d = HUNT;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      timer_q <= '0;
      ts_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ts_q    <= ts_d;
      err_q   <= err_d;
    end
  end

  // The top byte is taken straight from the bus so the strobe needs no extra cycle.
  assign ts_o        = {uart_data_i, ts_q};
  assign pkt_error_o = err_q;
  assign state_o     = state_q;

endmodule

// File: rtl/harp_sync_receiver.sv
// harp_sync_receiver: receive side of the Harp clock-synchronization link.
// Aligns a local seconds/sub-second counter to the boundary implied by each
// received timestamp packet and free-runs between packets.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   run         : enable; low clears counters, lock and the parser
//   uart_data   : received byte, qualified by uart_valid
//   uart_valid  : one-cycle strobe per received byte
//   seconds     : current Harp second
//   subsec      : clk cycles since the last second boundary
//   sec_tick    : one-cycle pulse in the first cycle of each new second
//   locked      : aligned to a received packet
//   pkt_error   : one-cycle pulse on a parse or timeout error
//   LED         : seconds[0]
module harp_sync_receiver
  import harp_pkg::*;
#(
  parameter int CLK_RATE_HZ         = 1000000,
  parameter int LAST_WORD_US        = 672,
  parameter int RX_LATENCY_CYCLES   = 100,
  parameter int BYTE_TIMEOUT_CYCLES = 2000,
  parameter int MISS_LIMIT          = 3,
  parameter int COUNTER_WIDTH       = $clog2(CLK_RATE_HZ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic [7:0]               uart_data,
  input  logic                     uart_valid,
  output logic [31:0]              seconds,
  output logic [COUNTER_WIDTH-1:0] subsec,
  output logic                     sec_tick,
  output logic                     locked,
  output logic                     pkt_error,
  output logic                     LED
);

  localparam longint BOUNDARY_DELAY_L =
    (longint'(LAST_WORD_US) * longint'(CLK_RATE_HZ)) / longint'(1000000)
    - longint'(RX_LATENCY_CYCLES);
  localparam int BOUNDARY_DELAY = int'(BOUNDARY_DELAY_L);

  if (BOUNDARY_DELAY_L < 2) begin : g_bad_boundary_delay
    $error("harp_sync_receiver: BOUNDARY_DELAY must be at least 2 cycles");
  end

  localparam int CD_W = (BOUNDARY_DELAY > 2) ? $clog2(BOUNDARY_DELAY) : 1;
  localparam int MC_W = $clog2(MISS_LIMIT + 1);
  // Counter is loaded at the final-byte edge; firing D-1 edges later puts
  // the tick in cycle v+D.
  localparam logic [CD_W-1:0]          CD_LOAD    = CD_W'(BOUNDARY_DELAY - 2);
  localparam logic [COUNTER_WIDTH-1:0] LAST_CYCLE = COUNTER_WIDTH'(CLK_RATE_HZ - 1);
  localparam logic [MC_W-1:0]          MISS_MAX   = MC_W'(MISS_LIMIT);

  logic [31:0]              ts;
  logic                     ts_valid;
  parser_state_e            parser_state;

  harp_packet_parser #(
    .BYTE_TIMEOUT_CYCLES(BYTE_TIMEOUT_CYCLES)
  ) u_parser (
    .clk         (clk),
    .reset       (reset),
    .run_i       (run),
    .uart_data_i (uart_data),
    .uart_valid_i(uart_valid),
    .ts_o        (ts),
    .ts_valid_o  (ts_valid),
    .pkt_error_o (pkt_error),
    .state_o     (parser_state)
  );

  logic [31:0]              seconds_q, seconds_d;
  logic [COUNTER_WIDTH-1:0] subsec_q, subsec_d;
  logic                     tick_q, tick_d;
  logic                     locked_q, locked_d;
  logic [MC_W-1:0]          miss_q, miss_d;
  logic                     armed_q, armed_d;
  logic [CD_W-1:0]          cd_q, cd_d;
  logic [31:0]              pend_ts_q, pend_ts_d;
  logic                     fire;

  always_comb begin
    seconds_d = seconds_q;
    subsec_d  = subsec_q + 1'b1;
    tick_d    = 1'b0;
    locked_d  = locked_q;
    miss_d    = miss_q;
    armed_d   = armed_q;
    cd_d      = cd_q;
    pend_ts_d = pend_ts_q;
    fire      = armed_q && (cd_q == '0);

    if (!run) begin
      seconds_d = '0;
      subsec_d  = '0;
      locked_d  = 1'b0;
      miss_d    = '0;
      armed_d   = 1'b0;
      cd_d      = '0;
    end else begin
      if (armed_q && !fire) begin
        cd_d = cd_q - 1'b1;
      end

      if (fire) begin
        seconds_d = pend_ts_q + 32'd1;
        subsec_d  = '0;
        tick_d    = 1'b1;
        locked_d  = 1'b1;
        miss_d    = '0;
        armed_d   = 1'b0;
      end else if (!armed_q && !ts_valid && subsec_q == LAST_CYCLE) begin
        // While a boundary is pending the wrap is held off and subsec keeps
        // counting past LAST_CYCLE, absorbing drift against the transmitter.
        seconds_d = seconds_q + 32'd1;
        subsec_d  = '0;
        tick_d    = 1'b1;
        if (miss_q != MISS_MAX) begin
          miss_d = miss_q + 1'b1;
        end
        if (miss_q + 1'b1 >= MISS_MAX) begin
          locked_d = 1'b0;
        end
      end

      // A newer packet restarts the countdown with its own timestamp.
      if (ts_valid) begin
        armed_d   = 1'b1;
        cd_d      = CD_LOAD;
        pend_ts_d = ts;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seconds_q <= '0;
      subsec_q  <= '0;
      tick_q    <= 1'b0;
      locked_q  <= 1'b0;
      miss_q    <= '0;
      armed_q   <= 1'b0;
      cd_q      <= '0;
      pend_ts_q <= '0;
    end else begin
      seconds_q <= seconds_d;
      subsec_q  <= subsec_d;
      tick_q    <= tick_d;
      locked_q  <= locked_d;
      miss_q    <= miss_d;
      armed_q   <= armed_d;
      cd_q      <= cd_d;
      pend_ts_q <= pend_ts_d;
    end
  end

  // A completed packet always leaves the parser hunting for the next header.
  a_ts_valid_to_hunt: assert property (
    @(posedge clk) disable iff (reset) ts_valid |=> (parser_state == HUNT)
  );

  assign seconds  = seconds_q;
  assign subsec   = subsec_q;
  assign sec_tick = tick_q;
  assign locked   = locked_q;
  assign LED      = seconds_q[0];

endmodule

// File: tb/tb_harp_sync_receiver.sv
// tb_harp_sync_receiver: directed bench for harp_sync_receiver.
// Runs with a 10 kHz clock rate and LAST_WORD_US scaled so the boundary
// delay is still 572 cycles while a free-run second is only 10000 cycles.
module tb_harp_sync_receiver;

  localparam int CLK_HZ = 10000;
  localparam int CW     = $clog2(CLK_HZ);
  localparam int D      = 572;   // 67200 us * 10 kHz / 1e6 - 100
  localparam int TO     = 2000;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [7:0]    uart_data;
  logic          uart_valid;
  logic [31:0]   seconds;
  logic [CW-1:0] subsec;
  logic          sec_tick;
  logic          locked;
  logic          pkt_error;
  logic          LED;

  always #5 clk = ~clk;

  harp_sync_receiver #(
    .CLK_RATE_HZ        (CLK_HZ),
    .LAST_WORD_US       (67200),
    .RX_LATENCY_CYCLES  (100),
    .BYTE_TIMEOUT_CYCLES(TO),
    .MISS_LIMIT         (3),
    .COUNTER_WIDTH      (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .uart_data (uart_data),
    .uart_valid(uart_valid),
    .seconds   (seconds),
    .subsec    (subsec),
    .sec_tick  (sec_tick),
    .locked    (locked),
    .pkt_error (pkt_error),
    .LED       (LED)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every tick must match the next expected seconds value.
  always @(negedge clk) begin
    if (pkt_error) err_cnt++;
    if (sec_tick) begin
      check("tick_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("tick_seconds", seconds, exp_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_valid = 1'b1;
    uart_data  = b;
    @(posedge clk);
    #1;
    uart_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] t);
    send_byte(8'hAA);
    send_byte(8'hAF);
    send_byte(t[7:0]);
    send_byte(t[15:8]);
    send_byte(t[23:16]);
    send_byte(t[31:24]);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called right after the final byte's sampling edge.
  task automatic expect_boundary(input string tag, input logic [31:0] exp_sec);
    wait_edges(D - 2);
    check({tag, "_pre_tick"}, 32'(sec_tick), 32'd0);
    wait_edges(1);
    check({tag, "_tick"}, 32'(sec_tick), 32'd1);
    check({tag, "_seconds"}, seconds, exp_sec);
    check({tag, "_subsec"}, 32'(subsec), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_wrap_sec[3]   = '{32'h22, 32'h23, 32'h24};
  logic        exp_wrap_lock[3]  = '{1'b1, 1'b1, 1'b0};
  logic        exp_wrap_led[3]   = '{1'b0, 1'b1, 1'b0};

  initial begin
    reset      = 1'b1;
    run        = 1'b1;
    uart_valid = 1'b0;
    uart_data  = 8'h00;
    wait_edges(3);
    check("rst_seconds", seconds, 32'd0);
    check("rst_subsec", 32'(subsec), 32'd0);
    check("rst_tick", 32'(sec_tick), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_pkt_error", 32'(pkt_error), 32'd0);
    check("rst_led", 32'(LED), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Clean packet, back-to-back bytes.
    exp_q.push_back(32'd6);
    send_pkt(32'h0000_0005);
    expect_boundary("clean", 32'd6);
    check("clean_led", 32'(LED), 32'd0);
    check("clean_no_err", 32'(err_cnt), 32'd0);

    // Truncated packet: timeout error 2000 edges after the last byte.
    send_byte(8'hAA);
    send_byte(8'hAF);
    send_byte(8'h05);
    wait_edges(TO - 1);
    check("timeout_pre", 32'(pkt_error), 32'd0);
    wait_edges(1);
    check("timeout_pulse", 32'(pkt_error), 32'd1);
    wait_edges(1);
    check("timeout_post", 32'(pkt_error), 32'd0);
    exp_q.push_back(32'd10);
    send_pkt(32'h0000_0009);
    expect_boundary("after_timeout", 32'd10);

    // Repeated sync byte, then a bad byte after AA.
    exp_q.push_back(32'd2);
    send_byte(8'hAA);
    send_pkt(32'h0000_0001);
    expect_boundary("double_aa", 32'd2);
    send_byte(8'hAA);
    send_byte(8'h12);
    check("bad_hdr_pulse", 32'(pkt_error), 32'd1);
    // Parser must be hunting: a header-less tail produces nothing.
    send_byte(8'hAF);
    send_byte(8'h07);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_edges(D + 20);
    check("hunt_err_count", 32'(err_cnt), 32'd2);

    // Countdown spanning the would-be wrap at subsec 9999.
    exp_q.push_back(32'h11);
    send_pkt(32'h0000_0010);
    expect_boundary("span_ref", 32'h11);
    exp_q.push_back(32'h21);
    wait_edges(9894);
    send_pkt(32'h0000_0020);
    wait_edges(D - 2);
    check("span_subsec", 32'(subsec), 32'd10470);
    check("span_pre_tick", 32'(sec_tick), 32'd0);
    wait_edges(1);
    check("span_tick", 32'(sec_tick), 32'd1);
    check("span_seconds", seconds, 32'h21);
    check("span_subsec0", 32'(subsec), 32'd0);
    check("span_led", 32'(LED), 32'd1);

    // Free-run: three wraps, lock lost on the third.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exp_wrap_sec[i]);
      wait_edges(CLK_HZ - 1);
      check("wrap_pre_subsec", 32'(subsec), 32'(CLK_HZ - 1));
      check("wrap_pre_tick", 32'(sec_tick), 32'd0);
      wait_edges(1);
      check("wrap_tick", 32'(sec_tick), 32'd1);
      check("wrap_seconds", seconds, exp_wrap_sec[i]);
      check("wrap_subsec", 32'(subsec), 32'd0);
      check("wrap_locked", 32'(locked), 32'(exp_wrap_lock[i]));
      check("wrap_led", 32'(LED), 32'(exp_wrap_led[i]));
    end

    // run low mid-countdown and mid-packet.
    exp_q.push_back(32'h41);
    send_pkt(32'h0000_0040);
    expect_boundary("relock", 32'h41);
    send_pkt(32'h0000_0050);
    send_byte(8'hAA);
    send_byte(8'hAF);
    send_byte(8'h02);
    @(negedge clk);
    run = 1'b0;
    wait_edges(1);
    check("runlow_seconds", seconds, 32'd0);
    check("runlow_subsec", 32'(subsec), 32'd0);
    check("runlow_locked", 32'(locked), 32'd0);
    check("runlow_tick", 32'(sec_tick), 32'd0);
    wait_edges(D + 100);
    check("runlow_hold_seconds", seconds, 32'd0);
    check("runlow_hold_subsec", 32'(subsec), 32'd0);
    @(negedge clk);
    run = 1'b1;
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_edges(D + 10);
    check("runlow_err_count", 32'(err_cnt), 32'd2);
    check("runlow_still_unlocked", 32'(locked), 32'd0);
    exp_q.push_back(32'h34);
    send_pkt(32'h0000_0033);
    expect_boundary("after_run", 32'h34);

    // Asynchronous reset mid-countdown.
    send_pkt(32'h0000_0060);
    wait_edges(50);
    #2;
    reset = 1'b1;
    #1;
    check("areset_seconds", seconds, 32'd0);
    check("areset_locked", 32'(locked), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_edges(D + 10);
    check("areset_no_lock", 32'(locked), 32'd0);
    check("areset_seconds_hold", seconds, 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_err_count", 32'(err_cnt), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
